inst_loader: RTL
================

// Module: inst_loader
// PURPOSE
//  Writer side of the instruction ROM: the pc/if_id path only reads the ROM, and this block fills it.
//  Consumes a byte stream from a UART receiver, parses a framed program image and emits word writes to
//  the ROM write port. Holds the core (o_core_hold -> core reset/hold) for the whole load.
//  Frame: 0xA5 | LEN_L | LEN_H | LEN x 4 data bytes (little-endian words) | CSUM.
// PARAMETERS
//  BASE_ADDR    32'h0   byte address of word 0; word k is written to BASE_ADDR + 4*k
//  MAX_WORDS    1024    largest accepted LEN; LEN > MAX_WORDS is an error
//  TIMEOUT_CYC  100000  max idle cycles between bytes inside a frame before abort (>=2)
// PORTS
//  i_Clk          in   1   clock
//  i_reset        in   1   asynchronous, active-low reset
//  i_rx_valid     in   1   one-cycle strobe: i_rx_byte valid (may be asserted every cycle)
//  i_rx_byte      in   8   received byte
//  o_rom_we       out  1   one-cycle ROM write strobe
//  o_rom_w_addr   out  32  ROM byte address, word-aligned
//  o_rom_w_data   out  32  ROM write data
//  o_core_hold    out  1   1 = core held in reset while a frame is in progress
//  o_done         out  1   sticky: last frame loaded with good checksum
//  o_err          out  1   sticky: last frame aborted (bad LEN, bad CSUM, timeout)
// BEHAVIOUR
//  Reset (i_reset=0, async): state IDLE; all outputs 0; byte/word counters, csum accumulator, timer = 0.
//  FSM: IDLE -> LEN0 -> LEN1 -> DATA -> CSUM -> IDLE. Transitions only on i_rx_valid, except timeout.
//  - IDLE: byte 0xA5 -> LEN0, set o_core_hold=1, clear o_done/o_err, csum=0. Other bytes ignored.
//  - LEN0: latch LEN[7:0]. LEN1: latch LEN[15:8]; LEN==0 -> CSUM; LEN>MAX_WORDS -> ERR action;
//    otherwise -> DATA with word index 0, byte lane 0.
//  - DATA: bytes fill lanes 0..3 (lane 0 = bits 7:0). On lane 3: next cycle o_rom_we=1,
//    o_rom_w_addr=BASE_ADDR+4*index, o_rom_w_data=assembled word; index++. After word LEN-1 -> CSUM.
//  - CSUM: pass if (sum of LEN_L, LEN_H, all data bytes, CSUM byte) mod 256 == 0 -> o_done=1;
//    else ERR action. Either way -> IDLE, o_core_hold=0 on the next cycle.
//  - ERR action: o_err=1, o_core_hold=0, -> IDLE. ROM words already written are NOT rolled back.
//  - 0xA5 inside a frame is data, never a resync.
//  - Timeout: the timer resets on each i_rx_valid and counts while state != IDLE. At TIMEOUT_CYC -> ERR action.
//  - Latency: the write strobe is registered, exactly 1 cycle after the 4th byte's i_rx_valid.
//    With back-to-back bytes every cycle, writes are at most 1 per 4 cycles, so no buffering is needed.
//  - o_rom_w_addr/o_rom_w_data hold their last value when o_rom_we=0.
//    Addresses wrap modulo 2^32, with no check.
//  - Async reset mid-frame: everything returns to the reset values immediately, and a partially written
//    image remains in ROM.
//  - o_done and o_err are never both 1. Both stay valid until the next accepted 0xA5 or reset.
// TESTING
//  1. Send A5 02 00 | 13 00 00 00 | 6F 00 00 00 | CSUM=0x7C -> we@0x0=0x00000013, we@0x4=0x0000006F;
//     o_done=1, o_err=0, hold 1 from A5 until 1 cycle after CSUM.
//  2. Same frame with CSUM=0x7D -> both writes occur; o_err=1, o_done=0, hold drops.
//  3. A5 00 00 00 -> no o_rom_we; o_done=1. A5 FF FF -> o_err=1 after LEN_H, and no writes.
//  4. Stall TIMEOUT_CYC cycles after the 2nd data byte -> o_err=1, return to IDLE; the next A5 clears o_err.
//  5. Noise 00 FF 13 before A5, and 0xA5 as a data byte, with bytes strobed every cycle -> the frame parses
//     correctly and writes are spaced 4 cycles apart.
//  6. Assert i_reset low mid-DATA -> outputs 0 asynchronously; a fresh frame then loads normally.

Source files
------------

// File: rtl/inst_loader.sv
// Instruction ROM loader: parses a framed program image from a UART byte stream
// and issues word writes to the ROM write port, holding the core for the duration.
module inst_loader #(
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int unsigned MAX_WORDS   = 1024,
   parameter int unsigned TIMEOUT_CYC = 100000
) (
   input  logic        i_Clk,
   input  logic        i_reset,
   input  logic        i_rx_valid,
   input  logic [7:0]  i_rx_byte,
   output logic        o_rom_we,
   output logic [31:0] o_rom_w_addr,
   output logic [31:0] o_rom_w_data,
   output logic        o_core_hold,
   output logic        o_done,
   output logic        o_err
);

   localparam int unsigned LEN_W = 16;
   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

   localparam logic [7:0]       SYNC_BYTE = 8'hA5;
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LEN0 = 3'd1;
   localparam logic [2:0] S_LEN1 = 3'd2;
   localparam logic [2:0] S_DATA = 3'd3;
   localparam logic [2:0] S_CSUM = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [1:0]       lane_q, lane_d;
   logic [23:0]      word_q, word_d;
   logic [7:0]       csum_q, csum_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;

   logic        we_d;
   logic [31:0] addr_d;
   logic [31:0] data_d;
   logic        hold_d;
   logic        done_d;
   logic        err_d;

   logic [7:0]       csum_sum;
   logic [LEN_W-1:0] len_full;
   logic             timeout;

   // State and output registers
   always_ff @(posedge i_Clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q      <= S_IDLE;
         len_q        <= '0;
         idx_q        <= '0;
         lane_q       <= '0;
         word_q       <= '0;
         csum_q       <= '0;
         tmr_q        <= '0;
         o_rom_we     <= 1'b0;
         o_rom_w_addr <= '0;
         o_rom_w_data <= '0;
         o_core_hold  <= 1'b0;
         o_done       <= 1'b0;
         o_err        <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         idx_q        <= idx_d;
         lane_q       <= lane_d;
         word_q       <= word_d;
         csum_q       <= csum_d;
         tmr_q        <= tmr_d;
         o_rom_we     <= we_d;
         o_rom_w_addr <= addr_d;
         o_rom_w_data <= data_d;
         o_core_hold  <= hold_d;
         o_done       <= done_d;
         o_err        <= err_d;
      end
   end

   // Frame parser: next state, counters and next output values
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      idx_d    = idx_q;
      lane_d   = lane_q;
      word_d   = word_q;
      csum_d   = csum_q;
      tmr_d    = tmr_q;
      we_d     = 1'b0;
      addr_d   = o_rom_w_addr;
      data_d   = o_rom_w_data;
      hold_d   = o_core_hold;
      done_d   = o_done;
      err_d    = o_err;

      csum_sum = csum_q + i_rx_byte;
      len_full = {i_rx_byte, len_q[7:0]};
      timeout  = (state_q != S_IDLE) && !i_rx_valid && (tmr_q == TMR_LAST);

      // Inter-byte idle timer, only meaningful inside a frame
      if (state_q != S_IDLE) begin
         if (i_rx_valid) begin
            tmr_d = '0;
         end else begin
            tmr_d = tmr_q + TMR_W'(1);
         end
      end

      if (timeout) begin
         state_d = S_IDLE;
         tmr_d   = '0;
         err_d   = 1'b1;
         hold_d  = 1'b0;
      end else if (i_rx_valid) begin
         case (state_q)
            S_IDLE: begin
               if (i_rx_byte == SYNC_BYTE) begin
                  state_d = S_LEN0;
                  hold_d  = 1'b1;
                  done_d  = 1'b0;
                  err_d   = 1'b0;
                  csum_d  = '0;
                  tmr_d   = '0;
               end
            end
            S_LEN0: begin
               len_d   = {8'h00, i_rx_byte};
               csum_d  = csum_sum;
               state_d = S_LEN1;
            end
            S_LEN1: begin
               len_d  = len_full;
               csum_d = csum_sum;
               idx_d  = '0;
               lane_d = '0;
               if (len_full == '0) begin
                  state_d = S_CSUM;
               end else if (32'(len_full) > MAX_WORDS) begin
                  state_d = S_IDLE;
                  tmr_d   = '0;
                  err_d   = 1'b1;
                  hold_d  = 1'b0;
               end else begin
                  state_d = S_DATA;
               end
            end
            S_DATA: begin
               csum_d = csum_sum;
               lane_d = lane_q + 2'd1;
               case (lane_q)
                  2'd0: word_d[7:0]   = i_rx_byte;
                  2'd1: word_d[15:8]  = i_rx_byte;
                  2'd2: word_d[23:16] = i_rx_byte;
                  2'd3: begin
                     we_d   = 1'b1;
                     addr_d = BASE_ADDR + {14'd0, idx_q, 2'b00};
                     data_d = {i_rx_byte, word_q};
                     idx_d  = idx_q + LEN_W'(1);
                     if (idx_q == len_q - LEN_W'(1)) begin
                        state_d = S_CSUM;
                     end
                  end
               endcase
            end
            S_CSUM: begin
               state_d = S_IDLE;
               tmr_d   = '0;
               hold_d  = 1'b0;
               if (csum_sum == 8'h00) begin
                  done_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
               hold_d  = 1'b0;
            end
         endcase
      end
   end

endmodule
